decode_ctrl: RTL
================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter OPW, default 6, opcode width; values below 6 are illegal.
REQ-002 Parameter REGW, default 5, register index width.
REQ-003 Parameter ALUOPW, default 6, aluop width; values below 6 are illegal; bits above 5 are driven 0.
REQ-004 Parameter MDU_LAT, default 4, mult/div latency in cycles; legal range 1..255.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  an instruction is present on opcode/funct/rs/rt.
REQ-008 opcode  in  OPW  primary opcode; funct  in  6  R-type function field.
REQ-009 rs, rt  in  REGW  source register indices.
REQ-010 ex_memread, ex_rt  in  1/REGW  EX-stage load flag and load destination, used for load-use detection.
REQ-011 stall_in  in  1  downstream hold; flush  in  1  kill the incoming instruction.
REQ-012 Outputs, all registered: jump, link, branch, memread, memwrite, memtoreg, regdst, regwrite, alusrc, out_valid, illegal, each 1 bit; aluop  ALUOPW.
REQ-013 stall_req  out  1  combinational; holds IF/ID this cycle. mdu_busy  out  1  registered; a mult/div is in flight.

Function
REQ-014 Instruction classes use the top 6 opcode bits (op):
- load = 100xxx
- store = 101xxx
- itype = 001xxx
- branch = 00010x
- j = 000010
- jal = 000011
- rtype = 000000
- mdu = rtype with funct 0110xx
- mfhilo = rtype with funct 0100x0
REQ-015 Decode-to-output latency SHALL be exactly 1 cycle.
REQ-016 Control outputs for an accepted instruction:
- jump = j|jal; link = jal.
- memread = load; memwrite = store; memtoreg = load.
- regdst = rtype; regwrite = load|rtype|itype|jal; alusrc = load|store|itype.
- aluop[0] = branch|itype; aluop[1] = rtype|itype; aluop[4:2] = op[2:0]; aluop[5] = itype.
REQ-017 Unclassified opcode SHALL load all controls 0, out_valid 1 and illegal 1 (single-cycle pulse).
REQ-018 Load-use hazard SHALL be detected when all of the following hold:
- in_valid and ex_memread;
- ex_rt != 0;
- ex_rt == rs, or ex_rt == rt for rtype/store/branch.
REQ-019 On a load-use hazard: stall_req = 1 and a bubble is loaded (all controls 0, out_valid 0).
REQ-020 MDU FSM states: IDLE and BUSY.
- IDLE -> BUSY on an accepted mdu instruction; the counter loads MDU_LAT-1.
- BUSY decrements the counter each cycle; at counter 0 -> IDLE.
- MDU_LAT = 1 gives one BUSY cycle.
REQ-021 While BUSY, an incoming mdu or mfhilo instruction SHALL raise stall_req and load a bubble.
REQ-022 mdu_busy = 1 exactly while the FSM is in BUSY.
REQ-023 Priority, highest first: rst, flush, stall_in, hazard, normal.
REQ-024 flush SHALL load a bubble, deassert stall_req and not start the MDU FSM. An in-flight MDU operation continues.
REQ-025 stall_in SHALL hold all registered outputs and suppress acceptance (no MDU start). The MDU counter still advances.
REQ-026 in_valid = 0 SHALL load a bubble.
REQ-027 An instruction is "accepted" when in_valid=1, not flushed, not stalled, and no hazard is present.

Reset
REQ-028 rst SHALL asynchronously clear every output register and aluop to 0, the FSM to IDLE and the counter to 0.
REQ-029 Reset during BUSY SHALL abort the operation; mdu_busy is 0 on the first edge after rst deasserts.

Structure
REQ-030 Shared package contents:
- opcode class constants;
- funct constants for mdu and mfhilo;
- aluop bit indices;
- FSM state encoding.
REQ-031 Sub-module mdu_tracker SHALL hold the MDU FSM and counter. Decode and hazard logic stay in decode_ctrl.

Verification
REQ-032 Each of opcodes 100011, 101011, 001000, 000100, 000010, 000011, 000000 applied with in_valid -> the next cycle shows the REQ-016 vector; 000011 gives link=1 and regwrite=1.
REQ-033 ex_memread=1, ex_rt=5, rtype with rs=5 -> stall_req=1, bubble. Same stimulus with ex_rt=0 -> no stall.
REQ-034 MDU_LAT=4: mult accepted, then mflo on the next cycle -> stall_req held for 4 cycles, then mflo accepted and mdu_busy falls.
REQ-035 flush and stall_in both set with a valid load -> bubble (flush wins). stall_in alone -> outputs unchanged for 3 held cycles.
REQ-036 Opcode 111111 -> illegal pulses for 1 cycle.
REQ-037 rst asserted mid-BUSY, asynchronously -> all outputs 0 immediately, FSM IDLE after release.

Source files
------------

// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: opcode classes, funct masks, aluop bit indices, MDU state and control bundle
package decode_ctrl_pkg;
  localparam logic [2:0] OPC_LOAD   = 3'b100;
  localparam logic [2:0] OPC_STORE  = 3'b101;
  localparam logic [2:0] OPC_ITYPE  = 3'b001;
  localparam logic [4:0] OPC_BRANCH = 5'b00010;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;
  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] FN_MDU_MASK    = 6'b111100;
  localparam logic [5:0] FN_MDU         = 6'b011000;
  localparam logic [5:0] FN_MFHILO_MASK = 6'b111101;
  localparam logic [5:0] FN_MFHILO      = 6'b010000;
  localparam int AOP_BI    = 0;
  localparam int AOP_RI    = 1;
  localparam int AOP_OP_LO = 2;
  localparam int AOP_OP_HI = 4;
  localparam int AOP_IT    = 5;
  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;
  typedef struct packed {
    logic       jump;
    logic       link;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
    logic       out_valid;
    logic       illegal;
    logic [5:0] aluop;
  } ctrl_t;
endpackage

// File: rtl/decode_ctrl_mdu_tracker.sv
// mdu_tracker: IDLE/BUSY FSM with latency counter for an in-flight mult/div
// ports: clk, rst (async, active-high), start (accepted mdu op), busy (FSM in BUSY)
module mdu_tracker
  import decode_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);
  localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 1);
  mdu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic idle, done;
  assign idle = state_q == MDU_IDLE;
  assign done = cnt_q == 8'd0;
  always_comb begin
    state_d = idle ? (start ? MDU_BUSY : MDU_IDLE) : (done ? MDU_IDLE : MDU_BUSY);
    cnt_d   = idle ? (start ? CNT_INIT : cnt_q) : (done ? 8'd0 : cnt_q - 8'd1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  assign busy = state_q == MDU_BUSY;
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: registered instruction decode with load-use and MDU interlocks
// ports: clk, rst (async, active-high); in_valid/opcode/funct/rs/rt instruction in;
//        ex_memread/ex_rt load in EX; stall_in hold, flush kill;
//        registered controls + aluop, out_valid, illegal, mdu_busy; stall_req combinational
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int REGW    = 5,
  parameter int ALUOPW  = 6,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPW-1:0]    opcode,
  input  logic [5:0]        funct,
  input  logic [REGW-1:0]   rs,
  input  logic [REGW-1:0]   rt,
  input  logic              ex_memread,
  input  logic [REGW-1:0]   ex_rt,
  input  logic              stall_in,
  input  logic              flush,
  output logic              jump,
  output logic              link,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              regdst,
  output logic              regwrite,
  output logic              alusrc,
  output logic              out_valid,
  output logic              illegal,
  output logic [ALUOPW-1:0] aluop,
  output logic              stall_req,
  output logic              mdu_busy
);
  logic [5:0] op;
  logic is_load, is_store, is_itype, is_branch, is_j, is_jal, is_rtype, is_mdu, is_mfhilo, known;
  logic hazard, mdu_stall, accept;
  ctrl_t dec, ctrl_d, ctrl_q;
  assign op        = opcode[OPW-1 -: 6];
  assign is_load   = op[5:3] == OPC_LOAD;
  assign is_store  = op[5:3] == OPC_STORE;
  assign is_itype  = op[5:3] == OPC_ITYPE;
  assign is_branch = op[5:1] == OPC_BRANCH;
  assign is_j      = op == OPC_J;
  assign is_jal    = op == OPC_JAL;
  assign is_rtype  = op == OPC_RTYPE;
  assign is_mdu    = is_rtype && (funct & FN_MDU_MASK) == FN_MDU;
  assign is_mfhilo = is_rtype && (funct & FN_MFHILO_MASK) == FN_MFHILO;
  assign known     = is_load | is_store | is_itype | is_branch | is_j | is_jal | is_rtype;
  // rt is only a source operand for rtype/store/branch; loads and itypes write rt
  assign hazard    = in_valid && ex_memread && ex_rt != '0 &&
                     (ex_rt == rs || (ex_rt == rt && (is_rtype | is_store | is_branch)));
  assign mdu_stall = in_valid && mdu_busy && (is_mdu | is_mfhilo);
  assign stall_req = !flush && !stall_in && (hazard | mdu_stall);
  assign accept    = in_valid && !flush && !stall_in && !hazard && !mdu_stall;
  always_comb begin
    dec           = '0;
    dec.jump      = is_j | is_jal;
    dec.link      = is_jal;
    dec.branch    = is_branch;
    dec.memread   = is_load;
    dec.memwrite  = is_store;
    dec.memtoreg  = is_load;
    dec.regdst    = is_rtype;
    dec.regwrite  = is_load | is_rtype | is_itype | is_jal;
    dec.alusrc    = is_load | is_store | is_itype;
    dec.out_valid = 1'b1;
    dec.illegal   = !known;
    dec.aluop[AOP_BI]               = known & (is_branch | is_itype);
    dec.aluop[AOP_RI]               = is_rtype | is_itype;
    dec.aluop[AOP_OP_HI:AOP_OP_LO]  = known ? op[2:0] : 3'b000;
    dec.aluop[AOP_IT]               = is_itype;
    ctrl_d = flush ? ctrl_t'(0) : stall_in ? ctrl_q : accept ? dec : ctrl_t'(0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  mdu_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk  (clk),
    .rst  (rst),
    .start(accept & is_mdu),
    .busy (mdu_busy)
  );
  assign jump      = ctrl_q.jump;
  assign link      = ctrl_q.link;
  assign branch    = ctrl_q.branch;
  assign memread   = ctrl_q.memread;
  assign memwrite  = ctrl_q.memwrite;
  assign memtoreg  = ctrl_q.memtoreg;
  assign regdst    = ctrl_q.regdst;
  assign regwrite  = ctrl_q.regwrite;
  assign alusrc    = ctrl_q.alusrc;
  assign out_valid = ctrl_q.out_valid;
  assign illegal   = ctrl_q.illegal;
  assign aluop     = ALUOPW'(ctrl_q.aluop);
endmodule
